uart_cmd_loader: RTL and testbench

Byte-level command controller behind the UART receiver. It consumes `rx_done_tick`/`dout` byte strobes and decodes a small command protocol. It assembles 32-bit words and writes them sequentially into the pipeline's instruction memory, and it issues run/step pulses to the pipeline control. It is the only master of the instruction-memory write port during program load.

---
 rtl/uart_cmd_loader_if.sv | 44 ++++
 rtl/uart_cmd_loader.sv | 186 ++++++++++++++++++
 tb/tb_uart_cmd_loader.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_loader_if.sv
// Byte-strobe input, instruction-memory write port and pipeline control bundle
// seen by the UART command loader.
interface uart_cmd_loader_if #(
  parameter int unsigned ADDR_W = 8
);

  logic              rx_done_tick;
  logic [7:0]        rx_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              run_pulse;
  logic              step_pulse;
  logic              load_done;
  logic              busy;
  logic              err;

  modport master (
    input  rx_done_tick,
    input  rx_data,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output run_pulse,
    output step_pulse,
    output load_done,
    output busy,
    output err
  );

  modport slave (
    output rx_done_tick,
    output rx_data,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    input  run_pulse,
    input  step_pulse,
    input  load_done,
    input  busy,
    input  err
  );

endinterface

// File: rtl/uart_cmd_loader.sv
// UART byte command decoder: loads 32-bit words into instruction memory and
// issues run/step pulses to the pipeline. All outputs are registered.
module uart_cmd_loader #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 100000,
  parameter int unsigned TO_W    = 17
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_cmd_loader_if.master  bus
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned ASM_W  = WORD_W - BYTE_W;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned IDX_W  = 2;

  localparam logic [BYTE_W-1:0] CMD_LOAD = 8'h01;
  localparam logic [BYTE_W-1:0] CMD_RUN  = 8'h02;
  localparam logic [BYTE_W-1:0] CMD_STEP = 8'h03;
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(3);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LEN  = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [ASM_W-1:0]    asm_q, asm_d;
  logic [TO_W-1:0]     to_q, to_d;

  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                run_q, run_d;
  logic                step_q, step_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;

  logic                tick;
  logic [BYTE_W-1:0]   byte_in;

  assign tick    = bus.rx_done_tick;
  assign byte_in = bus.rx_data;

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      asm_q       <= '0;
      to_q        <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      run_q       <= 1'b0;
      step_q      <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      asm_q       <= asm_d;
      to_q        <= to_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      run_q       <= run_d;
      step_q      <= step_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    asm_d       = asm_q;
    to_d        = '0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    run_d       = 1'b0;
    step_d      = 1'b0;
    done_d      = 1'b0;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        if (tick) begin
          case (byte_in)
            CMD_LOAD: begin
              state_d = S_LEN;
              err_d   = 1'b0;
              addr_d  = '0;
              idx_d   = '0;
            end
            CMD_RUN: begin
              err_d = 1'b0;
              run_d = 1'b1;
            end
            CMD_STEP: begin
              err_d  = 1'b0;
              step_d = 1'b1;
            end
            default: err_d = 1'b1;
          endcase
        end
      end

      S_LEN: begin
        if (tick) begin
          if (byte_in == '0) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d   = byte_in;
            idx_d   = '0;
            state_d = S_DATA;
          end
        end else if (to_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end

      S_DATA: begin
        if (tick) begin
          // Bytes arrive MSB first; the fourth completes the word without a register stage
          if (idx_q == IDX_LAST) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = addr_q;
            mem_wdata_d = {asm_q, byte_in};
            addr_d      = addr_q + ADDR_W'(1);
            cnt_d       = cnt_q - CNT_W'(1);
            idx_d       = '0;
            if (cnt_q == CNT_W'(1)) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            asm_d = {asm_q[ASM_W-BYTE_W-1:0], byte_in};
            idx_d = idx_q + IDX_W'(1);
          end
        end else if (to_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.run_pulse  = run_q;
  assign bus.step_pulse = step_q;
  assign bus.load_done  = done_q;
  assign bus.busy       = busy_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_uart_cmd_loader.sv
// Directed bench for uart_cmd_loader; memory writes are checked against a
// scoreboard queue filled as bytes are sent.
module tb_uart_cmd_loader;

  localparam int unsigned ADDR_W  = 2;
  localparam int unsigned TIMEOUT = 20;
  localparam int unsigned TO_W    = 5;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int n_run = 0;
  int n_step = 0;
  int n_done = 0;
  int n_wr = 0;

  wr_t exp_q[$];

  uart_cmd_loader_if #(.ADDR_W(ADDR_W)) bus ();

  uart_cmd_loader #(
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT),
    .TO_W   (TO_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; the byte is sampled on the following rising edge
  task automatic send(input logic [7:0] b);
    bus.rx_done_tick = 1'b1;
    bus.rx_data      = b;
    @(negedge clk);
    bus.rx_done_tick = 1'b0;
    bus.rx_data      = 8'h00;
  endtask

  task automatic push_word(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic send_word(input logic [31:0] d);
    send(d[31:24]);
    send(d[23:16]);
    send(d[15:8]);
    send(d[7:0]);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_outs"},
        {60'd0, bus.mem_we, bus.run_pulse, bus.step_pulse, bus.load_done}, 64'd0);
  endtask

  // Write monitor: every strobe must match the oldest expected write
  always @(negedge clk) begin
    if (bus.run_pulse)  n_run++;
    if (bus.step_pulse) n_step++;
    if (bus.load_done)  n_done++;
    if (bus.mem_we) begin
      n_wr++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 64'd1, 64'd0);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        chk("wr_addr", 64'(bus.mem_addr), 64'(w.addr));
        chk("wr_data", 64'(bus.mem_wdata), 64'(w.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bus.rx_done_tick = 1'b0;
    bus.rx_data      = 8'h00;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_outs", {bus.mem_we, bus.run_pulse, bus.step_pulse, bus.load_done,
                     bus.busy, bus.err}, 64'd0);
    chk("rst_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_wdata", 64'(bus.mem_wdata), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // LOAD two words
    push_word(2'd0, 32'hDEADBEEF);
    push_word(2'd1, 32'h12345678);
    send(8'h01);
    chk("load_busy_rise", 64'(bus.busy), 64'd1);
    send(8'h02);
    send_word(32'hDEADBEEF);
    chk("load_done_mid", 64'(bus.load_done), 64'd0);
    send(8'h12); send(8'h34); send(8'h56);
    send(8'h78);
    chk("load_done", 64'(bus.load_done), 64'd1);
    chk("load_we_with_done", 64'(bus.mem_we), 64'd1);
    chk("load_busy_fall", 64'(bus.busy), 64'd0);
    @(negedge clk);
    chk("load_done_1cyc", 64'(bus.load_done), 64'd0);
    chk("we_1cyc", 64'(bus.mem_we), 64'd0);
    chk("addr_hold", 64'(bus.mem_addr), 64'd1);
    chk("wdata_hold", 64'(bus.mem_wdata), 64'h12345678);

    // RUN then STEP
    send(8'h02);
    chk("run_pulse", 64'(bus.run_pulse), 64'd1);
    chk("run_busy", 64'(bus.busy), 64'd0);
    send(8'h03);
    chk("run_1cyc", 64'(bus.run_pulse), 64'd0);
    chk("step_pulse", 64'(bus.step_pulse), 64'd1);
    @(negedge clk);
    chk("step_1cyc", 64'(bus.step_pulse), 64'd0);

    // Illegal command sets err, next valid command clears it
    send(8'h7F);
    chk("bad_err", 64'(bus.err), 64'd1);
    chk_quiet("bad");
    chk("bad_busy", 64'(bus.busy), 64'd0);
    send(8'h02);
    chk("bad_clr_err", 64'(bus.err), 64'd0);
    chk("bad_then_run", 64'(bus.run_pulse), 64'd1);

    // Timeout mid-word: err after exactly TIMEOUT idle cycles, no write
    send(8'h01); send(8'h01); send(8'hAA); send(8'hBB);
    k = 0;
    while (bus.err !== 1'b1 && k < 3 * TIMEOUT) begin
      @(negedge clk);
      k++;
    end
    chk("to_cycles", 64'(k), 64'(TIMEOUT));
    chk("to_err", 64'(bus.err), 64'd1);
    chk("to_busy", 64'(bus.busy), 64'd0);
    chk_quiet("to");
    send(8'h01);
    chk("to_clr_err", 64'(bus.err), 64'd0);
    send(8'h00);
    chk("len0_done", 64'(bus.load_done), 64'd1);
    chk("len0_we", 64'(bus.mem_we), 64'd0);
    chk("len0_busy", 64'(bus.busy), 64'd0);

    // A byte arriving on the last allowed cycle is accepted
    push_word(2'd0, 32'h11223344);
    send(8'h01); send(8'h01);
    repeat (TIMEOUT - 1) @(negedge clk);
    chk("edge_no_err", 64'(bus.err), 64'd0);
    chk("edge_busy", 64'(bus.busy), 64'd1);
    send_word(32'h11223344);
    chk("edge_done", 64'(bus.load_done), 64'd1);
    chk("edge_err", 64'(bus.err), 64'd0);

    // Address wrap with five words into a four-word space
    for (int i = 1; i <= 5; i++) push_word(ADDR_W'(i - 1), 32'(i));
    send(8'h01); send(8'h05);
    for (int i = 1; i <= 5; i++) send_word(32'(i));
    chk("wrap_done", 64'(bus.load_done), 64'd1);
    chk("wrap_last_addr", 64'(bus.mem_addr), 64'd0);
    chk("wrap_last_data", 64'(bus.mem_wdata), 64'd5);

    // Asynchronous reset in the middle of a LOAD
    push_word(2'd0, 32'hDEADBEEF);
    send(8'h01); send(8'h02);
    send_word(32'hDEADBEEF);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_outs", {bus.mem_we, bus.run_pulse, bus.step_pulse, bus.load_done,
                      bus.busy, bus.err}, 64'd0);
    chk("arst_addr", 64'(bus.mem_addr), 64'd0);
    chk("arst_wdata", 64'(bus.mem_wdata), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_word(2'd0, 32'hCAFEF00D);
    send(8'h01); send(8'h01);
    send_word(32'hCAFEF00D);
    chk("post_rst_done", 64'(bus.load_done), 64'd1);
    @(negedge clk);

    // Totals across the run
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    chk("tot_writes", 64'(n_wr), 64'd10);
    chk("tot_run", 64'(n_run), 64'd2);
    chk("tot_step", 64'(n_step), 64'd1);
    chk("tot_done", 64'(n_done), 64'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
